exwb_stage: RTL and testbench

- Parametrised EX->WB pipeline stage register for the 4-stage core.
- Carries the write-back control, the address, the ALU result and the destination register index from EX to WB.
- Adds a valid/ready handshake with a 2-entry skid buffer, so WB back-pressure does not create a combinational ready path into EX.
- Adds a synchronous flush and a forwarding tap from the entry currently presented to WB.

---
 rtl/exwb_pkg.sv | 15 +
 rtl/exwb_slot.sv | 49 ++++
 rtl/exwb_stage.sv | 148 ++++++++++++++
 tb/tb_exwb_stage.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/exwb_pkg.sv
// Shared types and constants for the EX->WB stage register.
package exwb_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_t;

  localparam int unsigned DATA_W_DEF = 8;
  localparam int unsigned ADDR_W_DEF = 8;
  localparam int unsigned RIDX_W_DEF = 3;
  localparam int unsigned PERF_W     = 16;

endpackage

// File: rtl/exwb_slot.sv
// One EX->WB entry: valid flag plus payload, with load, clear and async reset.
module exwb_slot #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned RIDX_W = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              ld,
  input  logic              d_regwrite,
  input  logic              d_writesrc,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_result,
  input  logic [RIDX_W-1:0] d_rd,
  output logic              q_valid,
  output logic              q_regwrite,
  output logic              q_writesrc,
  output logic [ADDR_W-1:0] q_addr,
  output logic [DATA_W-1:0] q_result,
  output logic [RIDX_W-1:0] q_rd
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q_valid    <= 1'b0;
      q_regwrite <= 1'b0;
      q_writesrc <= 1'b0;
      q_addr     <= '0;
      q_result   <= '0;
      q_rd       <= '0;
    end else if (clr) begin
      q_valid    <= 1'b0;
      q_regwrite <= 1'b0;
      q_writesrc <= 1'b0;
      q_addr     <= '0;
      q_result   <= '0;
      q_rd       <= '0;
    end else if (ld) begin
      q_valid    <= 1'b1;
      q_regwrite <= d_regwrite;
      q_writesrc <= d_writesrc;
      q_addr     <= d_addr;
      q_result   <= d_result;
      q_rd       <= d_rd;
    end
  end

endmodule

// File: rtl/exwb_stage.sv
// EX->WB stage register with 2-entry skid buffer, flush and forwarding tap.
// Optional WB stall counter enabled by defining EXWB_PERF_CNT_EN.
module exwb_stage
  import exwb_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEF,
  parameter int unsigned ADDR_W = ADDR_W_DEF,
  parameter int unsigned RIDX_W = RIDX_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_regwrite,
  input  logic              in_writesrc,
  input  logic [ADDR_W-1:0] in_addr,
  input  logic [DATA_W-1:0] in_result,
  input  logic [RIDX_W-1:0] in_rd,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_regwrite,
  output logic              out_writesrc,
  output logic [ADDR_W-1:0] out_addr,
  output logic [DATA_W-1:0] out_result,
  output logic [RIDX_W-1:0] out_rd,
  output logic              fwd_valid,
  output logic [RIDX_W-1:0] fwd_rd,
  output logic [DATA_W-1:0] fwd_data,
  output logic [PERF_W-1:0] perf_stall_cnt
);

  if (ADDR_W > DATA_W) begin : g_width_chk
    $error("exwb_stage: ADDR_W must not exceed DATA_W");
  end

  logic              main_v, main_rw, main_ws;
  logic [ADDR_W-1:0] main_addr;
  logic [DATA_W-1:0] main_res;
  logic [RIDX_W-1:0] main_rd;
  logic              skid_v, skid_rw, skid_ws;
  logic [ADDR_W-1:0] skid_addr;
  logic [DATA_W-1:0] skid_res;
  logic [RIDX_W-1:0] skid_rd;

  logic              main_ld, main_clr, main_from_skid;
  logic              skid_ld, skid_clr;
  logic              acc, drn;
  logic              md_rw, md_ws;
  logic [ADDR_W-1:0] md_addr;
  logic [DATA_W-1:0] md_res;
  logic [RIDX_W-1:0] md_rd;
  state_t            state;

  // skid_v is a flop, so in_ready has no combinational path from out_ready
  assign in_ready = ~skid_v;
  assign acc      = in_valid & in_ready;
  assign drn      = main_v & out_ready;

  always_comb begin
    state = EMPTY;
    if (skid_v)      state = TWO;
    else if (main_v) state = ONE;
  end

  always_comb begin
    main_ld        = 1'b0;
    main_clr       = 1'b0;
    main_from_skid = 1'b0;
    skid_ld        = 1'b0;
    skid_clr       = 1'b0;
    if (flush) begin
      main_clr = 1'b1;
      skid_clr = 1'b1;
    end else begin
      unique case (state)
        EMPTY: main_ld = acc;
        ONE: begin
          if (acc && drn)       main_ld  = 1'b1;
          else if (acc)         skid_ld  = 1'b1;
          else if (drn)         main_clr = 1'b1;
        end
        TWO: begin
          if (drn) begin
            main_ld        = 1'b1;
            main_from_skid = 1'b1;
            skid_clr       = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    md_rw   = in_regwrite;
    md_ws   = in_writesrc;
    md_addr = in_addr;
    md_res  = in_result;
    md_rd   = in_rd;
    if (main_from_skid) begin
      md_rw   = skid_rw;
      md_ws   = skid_ws;
      md_addr = skid_addr;
      md_res  = skid_res;
      md_rd   = skid_rd;
    end
  end

  exwb_slot #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .RIDX_W(RIDX_W)) u_main (
    .clk(clk), .rst(rst), .clr(main_clr), .ld(main_ld),
    .d_regwrite(md_rw), .d_writesrc(md_ws), .d_addr(md_addr),
    .d_result(md_res), .d_rd(md_rd),
    .q_valid(main_v), .q_regwrite(main_rw), .q_writesrc(main_ws),
    .q_addr(main_addr), .q_result(main_res), .q_rd(main_rd)
  );

  exwb_slot #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .RIDX_W(RIDX_W)) u_skid (
    .clk(clk), .rst(rst), .clr(skid_clr), .ld(skid_ld),
    .d_regwrite(in_regwrite), .d_writesrc(in_writesrc), .d_addr(in_addr),
    .d_result(in_result), .d_rd(in_rd),
    .q_valid(skid_v), .q_regwrite(skid_rw), .q_writesrc(skid_ws),
    .q_addr(skid_addr), .q_result(skid_res), .q_rd(skid_rd)
  );

  assign out_valid    = main_v;
  assign out_regwrite = main_v & main_rw;
  assign out_writesrc = main_ws;
  assign out_addr     = main_addr;
  assign out_result   = main_res;
  assign out_rd       = main_rd;

  assign fwd_valid = out_valid & out_regwrite;
  assign fwd_rd    = main_rd;
  assign fwd_data  = main_ws ? DATA_W'(main_addr) : main_res;

`ifdef EXWB_PERF_CNT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      perf_stall_cnt <= '0;
    else if (main_v && !out_ready && perf_stall_cnt != '1)
      perf_stall_cnt <= perf_stall_cnt + 1'b1;
  end
`else
  assign perf_stall_cnt = '0;
`endif

endmodule

// File: tb/tb_exwb_stage.sv
// Directed self-checking bench for exwb_stage (default widths 8/8/3).
module tb_exwb_stage;
  import exwb_pkg::*;

  logic        clk = 1'b0;
  logic        rst, flush, in_valid, in_ready, in_regwrite, in_writesrc;
  logic [7:0]  in_addr, in_result;
  logic [2:0]  in_rd;
  logic        out_valid, out_ready, out_regwrite, out_writesrc;
  logic [7:0]  out_addr, out_result;
  logic [2:0]  out_rd;
  logic        fwd_valid;
  logic [2:0]  fwd_rd;
  logic [7:0]  fwd_data;
  logic [15:0] perf_stall_cnt;

  int unsigned errors = 0;
  int unsigned checks = 0;
  logic        seen_rd5;

  exwb_stage #(.DATA_W(8), .ADDR_W(8), .RIDX_W(3)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_regwrite(in_regwrite), .in_writesrc(in_writesrc),
    .in_addr(in_addr), .in_result(in_result), .in_rd(in_rd),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_regwrite(out_regwrite), .out_writesrc(out_writesrc),
    .out_addr(out_addr), .out_result(out_result), .out_rd(out_rd),
    .fwd_valid(fwd_valid), .fwd_rd(fwd_rd), .fwd_data(fwd_data),
    .perf_stall_cnt(perf_stall_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic rw, input logic ws,
                       input logic [7:0] a, input logic [7:0] r, input logic [2:0] d);
    in_valid    = v;
    in_regwrite = rw;
    in_writesrc = ws;
    in_addr     = a;
    in_result   = r;
    in_rd       = d;
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; out_ready = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 3'd0);
    #2;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_perf", 32'(perf_stall_cnt), 32'd0);
    step();
    rst = 1'b0;

    // streaming
    out_ready = 1'b1;
    drive(1'b1, 1'b1, 1'b0, 8'h01, 8'h11, 3'd1); step();
    check("str_res0", 32'(out_result), 32'h11);
    check("str_rdy0", 32'(in_ready), 32'd1);
    drive(1'b1, 1'b1, 1'b0, 8'h02, 8'h22, 3'd2); step();
    check("str_res1", 32'(out_result), 32'h22);
    check("str_rdy1", 32'(in_ready), 32'd1);
    drive(1'b1, 1'b1, 1'b0, 8'h03, 8'h33, 3'd3); step();
    check("str_res2", 32'(out_result), 32'h33);
    check("str_rd2", 32'(out_rd), 32'd3);
    drive(1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 3'd0); step();
    check("str_empty", 32'(out_valid), 32'd0);

    // back-pressure
    out_ready = 1'b0;
    drive(1'b1, 1'b1, 1'b0, 8'h00, 8'hA1, 3'd1); step();
    check("bp_res_a1", 32'(out_result), 32'hA1);
    check("bp_rdy_a1", 32'(in_ready), 32'd1);
    drive(1'b1, 1'b1, 1'b0, 8'h00, 8'hA2, 3'd2); step();
    check("bp_rdy_full", 32'(in_ready), 32'd0);
    check("bp_hold_a1", 32'(out_result), 32'hA1);
    drive(1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 3'd0); step();
    check("bp_hold2_a1", 32'(out_result), 32'hA1);
    check("bp_stall_perf", 32'(perf_stall_cnt) == 32'd0 ? 32'd0 : 32'd1,
`ifdef EXWB_PERF_CNT_EN
          32'd1);
`else
          32'd0);
`endif
    out_ready = 1'b1; step();
    check("bp_drain_a2", 32'(out_result), 32'hA2);
    check("bp_rdy_back", 32'(in_ready), 32'd1);
    step();
    check("bp_empty", 32'(out_valid), 32'd0);

    // flush in state TWO with in_valid high
    out_ready = 1'b0;
    drive(1'b1, 1'b1, 1'b0, 8'h00, 8'hB1, 3'd1); step();
    drive(1'b1, 1'b1, 1'b0, 8'h00, 8'hB2, 3'd2); step();
    check("fl_two", 32'(in_ready), 32'd0);
    flush = 1'b1;
    drive(1'b1, 1'b1, 1'b0, 8'h00, 8'hB5, 3'd5); step();
    flush = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 3'd0);
    check("fl_valid", 32'(out_valid), 32'd0);
    check("fl_ready", 32'(in_ready), 32'd1);
    check("fl_rd_clr", 32'(out_rd), 32'd0);
    // flush in state ONE where the accept really is offered
    drive(1'b1, 1'b1, 1'b0, 8'h00, 8'hC1, 3'd1); step();
    flush = 1'b1;
    drive(1'b1, 1'b1, 1'b0, 8'h00, 8'hC5, 3'd5); step();
    flush = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 3'd0);
    check("fl1_valid", 32'(out_valid), 32'd0);
    out_ready = 1'b1;
    seen_rd5 = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (out_valid && out_rd == 3'd5) seen_rd5 = 1'b1;
      step();
    end
    check("fl_no_rd5", 32'(seen_rd5), 32'd0);

    // forwarding
    out_ready = 1'b0;
    drive(1'b1, 1'b1, 1'b1, 8'h3C, 8'h99, 3'd2); step();
    check("fw_valid", 32'(fwd_valid), 32'd1);
    check("fw_rd", 32'(fwd_rd), 32'd2);
    check("fw_data_addr", 32'(fwd_data), 32'h3C);
    out_ready = 1'b1;
    drive(1'b1, 1'b1, 1'b0, 8'h3C, 8'h99, 3'd4); step();
    check("fw_data_res", 32'(fwd_data), 32'h99);
    check("fw_rd4", 32'(fwd_rd), 32'd4);
    drive(1'b1, 1'b0, 1'b0, 8'h00, 8'h55, 3'd6); step();
    check("fw_norw", 32'(fwd_valid), 32'd0);
    check("fw_norw_res", 32'(out_result), 32'h55);
    drive(1'b0, 1'b1, 1'b0, 8'h00, 8'h00, 3'd0); step();
    check("fw_gate_rw", 32'(out_regwrite), 32'd0);
    check("fw_gate_fv", 32'(fwd_valid), 32'd0);

    // asynchronous reset with both slots full
    out_ready = 1'b0;
    drive(1'b1, 1'b1, 1'b0, 8'h00, 8'hD1, 3'd1); step();
    drive(1'b1, 1'b1, 1'b0, 8'h00, 8'hD2, 3'd2); step();
    drive(1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 3'd0);
    check("ar_full", 32'(in_ready), 32'd0);
    #2 rst = 1'b1;
    #1;
    check("ar_valid", 32'(out_valid), 32'd0);
    check("ar_ready", 32'(in_ready), 32'd1);
    check("ar_result", 32'(out_result), 32'd0);
    check("ar_fwd", 32'(fwd_valid), 32'd0);
    check("ar_perf", 32'(perf_stall_cnt), 32'd0);
    step();
    rst = 1'b0;

    // stall counter: entry lands, then 10 stalled cycles
    drive(1'b1, 1'b1, 1'b0, 8'h00, 8'hE1, 3'd1); step();
    drive(1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 3'd0);
    check("pf_start", 32'(perf_stall_cnt), 32'd0);
    for (int i = 0; i < 10; i++) step();
`ifdef EXWB_PERF_CNT_EN
    check("pf_ten", 32'(perf_stall_cnt), 32'd10);
    flush = 1'b1; step(); flush = 1'b0;
    check("pf_flush_keep", 32'(perf_stall_cnt), 32'd11);
    drive(1'b1, 1'b1, 1'b0, 8'h00, 8'hE2, 3'd1); step();
    drive(1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 3'd0);
    for (int i = 0; i < 65524; i++) step();
    check("pf_max", 32'(perf_stall_cnt), 32'hFFFF);
    for (int i = 0; i < 5; i++) step();
    check("pf_sat", 32'(perf_stall_cnt), 32'hFFFF);
`else
    check("pf_tied", 32'(perf_stall_cnt), 32'd0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
